// File: rtl/prism_in_cond_if.sv
// Peripheral register bus shared with the PRISM controller: 6-bit address,
// 32-bit write data qualified by data_write_n, combinational read data.
interface prism_in_cond_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [31:0] data_out;

    modport master (
        output address,
        output data_in,
        output data_write_n,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_in,
        input  data_write_n,
        output data_out
    );
endinterface

// File: rtl/prism_in_cond.sv
// Input conditioning ahead of the PRISM in_data inputs: per-bit debounce with
// programmable persistence, polarity inversion, and sticky edge flags that
// drive a maskable interrupt. Configured over the PRISM register bus.
module prism_in_cond #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in_i,
    prism_in_cond_if.slave   bus,
    output logic [WIDTH-1:0] cond_out_o,
    output logic             edge_irq_o
);

    localparam logic [5:0] ADDR_CFG   = 6'h30;
    localparam logic [5:0] ADDR_FLAGS = 6'h34;
    localparam logic [5:0] ADDR_IRQEN = 6'h38;

    // Configuration and status registers
    logic [CNT_W-1:0] flt_len_q,   flt_len_d;
    logic [WIDTH-1:0] inv_mask_q,  inv_mask_d;
    logic [WIDTH-1:0] flt_en_q,    flt_en_d;
    logic [WIDTH-1:0] rise_flag_q, rise_flag_d;
    logic [WIDTH-1:0] fall_flag_q, fall_flag_d;
    logic [WIDTH-1:0] rise_en_q,   rise_en_d;
    logic [WIDTH-1:0] fall_en_q,   fall_en_d;

    // Per-bit debounce and edge-detect state
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic             wr_en;
    logic             wr_cfg;
    logic             wr_flags;
    logic             wr_irqen;
    logic [WIDTH-1:0] rise_det;
    logic [WIDTH-1:0] fall_det;
    logic [WIDTH-1:0] flag_clr_rise;
    logic [WIDTH-1:0] flag_clr_fall;
    logic             unused_bus_bits;

    // Only a full 32-bit write (data_write_n == 2'b10) touches the registers.
    assign wr_en    = (bus.data_write_n == 2'b10);
    assign wr_cfg   = wr_en && (bus.address == ADDR_CFG);
    assign wr_flags = wr_en && (bus.address == ADDR_FLAGS);
    assign wr_irqen = wr_en && (bus.address == ADDR_IRQEN);

    assign cond_out_o = stable_q ^ inv_mask_q;
    assign rise_det   =  cond_out_o & ~prev_q;
    assign fall_det   = ~cond_out_o &  prev_q;

    assign flag_clr_rise = wr_flags ? bus.data_in[0 +: WIDTH] : '0;
    assign flag_clr_fall = wr_flags ? bus.data_in[8 +: WIDTH] : '0;

    assign edge_irq_o = |((rise_flag_q & rise_en_q) | (fall_flag_q & fall_en_q));

    // Reserved write-data bits have no home; fold them into a sink.
    assign unused_bus_bits = &{1'b0, bus.data_in};

    // Debounce next state: stable follows pin_in after N consecutive mismatches.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (pin_in_i[i] != stable_q[i]) begin
                // The >= compare lets a shrinking N take effect on the next
                // mismatch instead of letting cnt run past the new limit.
                if (!flt_en_q[i] || (flt_len_q == '0) ||
                    (cnt_q[i] >= flt_len_q - CNT_W'(1))) begin
                    stable_d[i] = pin_in_i[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register-file next state; a detected edge overrides a same-cycle W1C clear.
    always_comb begin
        flt_len_d   = flt_len_q;
        inv_mask_d  = inv_mask_q;
        flt_en_d    = flt_en_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        if (wr_cfg) begin
            flt_len_d  = bus.data_in[CNT_W-1:0];
            inv_mask_d = bus.data_in[8  +: WIDTH];
            flt_en_d   = bus.data_in[16 +: WIDTH];
        end
        if (wr_irqen) begin
            rise_en_d = bus.data_in[0 +: WIDTH];
            fall_en_d = bus.data_in[8 +: WIDTH];
        end
        rise_flag_d = (rise_flag_q & ~flag_clr_rise) | rise_det;
        fall_flag_d = (fall_flag_q & ~flag_clr_fall) | fall_det;
    end

    // Combinational read mux; unmapped addresses and reserved bits read 0.
    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            ADDR_CFG: begin
                bus.data_out[CNT_W-1:0]   = flt_len_q;
                bus.data_out[8  +: WIDTH] = inv_mask_q;
                bus.data_out[16 +: WIDTH] = flt_en_q;
            end
            ADDR_FLAGS: begin
                bus.data_out[0 +: WIDTH] = rise_flag_q;
                bus.data_out[8 +: WIDTH] = fall_flag_q;
            end
            ADDR_IRQEN: begin
                bus.data_out[0 +: WIDTH] = rise_en_q;
                bus.data_out[8 +: WIDTH] = fall_en_q;
            end
            default: bus.data_out = '0;
        endcase
    end

    // State update with synchronous reset taking priority over bus writes.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_len_q   <= '0;
            inv_mask_q  <= '0;
            flt_en_q    <= '0;
            rise_flag_q <= '0;
            fall_flag_q <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            stable_q    <= '0;
            prev_q      <= '0;
            // NOTE: the counter array is small and must restart cleanly, so it is reset like any register.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            flt_len_q   <= flt_len_d;
            inv_mask_q  <= inv_mask_d;
            flt_en_q    <= flt_en_d;
            rise_flag_q <= rise_flag_d;
            fall_flag_q <= fall_flag_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            stable_q    <= stable_d;
            prev_q      <= cond_out_o;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_prism_in_cond.sv
// Self-checking bench for prism_in_cond: one table row per clock cycle, with
// expectations queued at drive time and compared just after the clock edge.
module tb_prism_in_cond;

    typedef struct {
        logic        rst;
        logic [6:0]  pin;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  wn;
        logic [6:0]  cond;
        logic        irq;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic [6:0]  cond;
        logic        irq;
        logic [31:0] rd;
        int          idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] pin_in;
    logic [6:0] cond_out;
    logic       edge_irq;

    prism_in_cond_if bus ();

    prism_in_cond #(.WIDTH(7), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pin_in_i   (pin_in),
        .bus        (bus),
        .cond_out_o (cond_out),
        .edge_irq_o (edge_irq)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_step = 0;
    exp_t sb[$];
    vec_t tbl[38];

    function automatic vec_t mk(input logic r, input logic [6:0] p, input logic [5:0] a,
                                input logic [31:0] w, input logic [1:0] n,
                                input logic [6:0] c, input logic i, input logic [31:0] d);
        vec_t v;
        v.rst = r; v.pin = p; v.addr = a; v.wdata = w; v.wn = n;
        v.cond = c; v.irq = i; v.rd = d;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, got, want);
        end
    endtask

    // Drive one cycle, queue its expectation, compare just after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        rst              = v.rst;
        pin_in           = v.pin;
        bus.address      = v.addr;
        bus.data_in      = v.wdata;
        bus.data_write_n = v.wn;
        e.cond = v.cond; e.irq = v.irq; e.rd = v.rd; e.idx = n_step;
        sb.push_back(e);
        n_step++;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("cond_out", g.idx, {25'd0, cond_out}, {25'd0, g.cond});
        check("edge_irq", g.idx, {31'd0, edge_irq}, {31'd0, g.irq});
        check("data_out", g.idx, bus.data_out, g.rd);
    endtask

    initial begin
        rst = 1'b1; pin_in = '0;
        bus.address = '0; bus.data_in = '0; bus.data_write_n = 2'b11;

        // Reset with pins high, then release: cond follows, flags one cycle later
        tbl[0]  = mk(1, 7'h7F, 6'h30, 32'h0, 2'b11, 7'h00, 0, 32'h0);
        tbl[1]  = mk(1, 7'h7F, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h0);
        tbl[2]  = mk(1, 7'h7F, 6'h38, 32'h0, 2'b11, 7'h00, 0, 32'h0);
        tbl[3]  = mk(0, 7'h7F, 6'h34, 32'h0, 2'b11, 7'h7F, 0, 32'h0);
        tbl[4]  = mk(0, 7'h7F, 6'h34, 32'h0, 2'b11, 7'h7F, 0, 32'h7F);
        tbl[5]  = mk(0, 7'h7F, 6'h34, 32'h7F, 2'b10, 7'h7F, 0, 32'h0);
        tbl[6]  = mk(0, 7'h00, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h0);
        tbl[7]  = mk(0, 7'h00, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h7F00);
        tbl[8]  = mk(0, 7'h00, 6'h34, 32'h7F00, 2'b10, 7'h00, 0, 32'h0);
        // Debounce N=5 on bit 0: 4-cycle glitch vanishes, 5-cycle level passes
        tbl[9]  = mk(0, 7'h00, 6'h30, 32'h00010005, 2'b10, 7'h00, 0, 32'h00010005);
        for (int i = 10; i <= 13; i++) tbl[i] = mk(0, 7'h01, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h0);
        tbl[14] = mk(0, 7'h00, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h0);
        for (int i = 15; i <= 18; i++) tbl[i] = mk(0, 7'h01, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h0);
        tbl[19] = mk(0, 7'h01, 6'h34, 32'h0, 2'b11, 7'h01, 0, 32'h0);
        tbl[20] = mk(0, 7'h01, 6'h34, 32'h0, 2'b11, 7'h01, 0, 32'h1);
        tbl[21] = mk(0, 7'h01, 6'h30, 32'h0, 2'b10, 7'h01, 0, 32'h0);
        tbl[22] = mk(0, 7'h01, 6'h34, 32'h1, 2'b10, 7'h01, 0, 32'h0);
        // Falling-edge interrupt enable, then inversion creates a masked rise
        tbl[23] = mk(0, 7'h00, 6'h38, 32'h100, 2'b10, 7'h00, 0, 32'h100);
        tbl[24] = mk(0, 7'h00, 6'h34, 32'h0, 2'b11, 7'h00, 1, 32'h100);
        tbl[25] = mk(0, 7'h00, 6'h34, 32'h100, 2'b10, 7'h00, 0, 32'h0);
        tbl[26] = mk(0, 7'h00, 6'h30, 32'h100, 2'b10, 7'h01, 0, 32'h100);
        tbl[27] = mk(0, 7'h00, 6'h34, 32'h0, 2'b11, 7'h01, 0, 32'h1);
        tbl[28] = mk(0, 7'h01, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h1);
        tbl[29] = mk(0, 7'h01, 6'h34, 32'h0, 2'b11, 7'h00, 1, 32'h101);
        tbl[30] = mk(0, 7'h01, 6'h34, 32'h101, 2'b10, 7'h00, 0, 32'h0);
        // Set beats same-cycle clear on bit 2, second clear drops irq
        tbl[31] = mk(0, 7'h01, 6'h38, 32'h104, 2'b10, 7'h00, 0, 32'h104);
        tbl[32] = mk(0, 7'h05, 6'h34, 32'h0, 2'b11, 7'h04, 0, 32'h0);
        tbl[33] = mk(0, 7'h05, 6'h34, 32'h4, 2'b10, 7'h04, 1, 32'h4);
        tbl[34] = mk(0, 7'h05, 6'h34, 32'h4, 2'b10, 7'h04, 0, 32'h0);
        // Narrow writes ignored, unmapped address reads 0
        tbl[35] = mk(0, 7'h05, 6'h30, 32'hFFFFFFFF, 2'b00, 7'h04, 0, 32'h100);
        tbl[36] = mk(0, 7'h05, 6'h30, 32'hFFFFFFFF, 2'b01, 7'h04, 0, 32'h100);
        tbl[37] = mk(0, 7'h05, 6'h3C, 32'hFFFFFFFF, 2'b10, 7'h04, 0, 32'h0);

        for (int i = 0; i < 38; i++) step(tbl[i]);

        // N=200 on bit 1, 50 mismatching cycles, then N=10: next mismatch passes
        step(mk(0, 7'h05, 6'h30, 32'h000201C8, 2'b10, 7'h04, 0, 32'h000201C8));
        for (int i = 0; i < 50; i++)
            step(mk(0, 7'h07, 6'h30, 32'h0, 2'b11, 7'h04, 0, 32'h000201C8));
        step(mk(0, 7'h07, 6'h30, 32'h0002010A, 2'b10, 7'h04, 0, 32'h0002010A));
        step(mk(0, 7'h07, 6'h30, 32'h0, 2'b11, 7'h06, 0, 32'h0002010A));

        // Reset mid-count with a concurrent write: reset wins, count abandoned
        step(mk(0, 7'h07, 6'h30, 32'h00080105, 2'b10, 7'h06, 0, 32'h00080105));
        step(mk(0, 7'h0F, 6'h30, 32'h0, 2'b11, 7'h06, 0, 32'h00080105));
        step(mk(0, 7'h0F, 6'h30, 32'h0, 2'b11, 7'h06, 0, 32'h00080105));
        step(mk(1, 7'h0F, 6'h30, 32'hFFFFFFFF, 2'b10, 7'h00, 0, 32'h0));
        step(mk(1, 7'h0F, 6'h34, 32'h0, 2'b11, 7'h00, 0, 32'h0));
        step(mk(0, 7'h0F, 6'h34, 32'h0, 2'b11, 7'h0F, 0, 32'h0));
        step(mk(0, 7'h0F, 6'h34, 32'h0, 2'b11, 7'h0F, 0, 32'h0F));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/prism_in_cond.md
# prism_in_cond

Input conditioning stage that sits directly upstream of the PRISM controller's `in_data[6:0]` inputs. It takes the seven synchronized PMOD input bits, and for each bit applies:

- an optional per-bit debounce filter with a programmable persistence length;
- a per-bit polarity inversion;
- sticky rising/falling edge flags with a maskable interrupt.

Configuration and status are exposed on the same 6-bit peripheral register bus as the PRISM block.

## Interface

Parameters:

- `WIDTH`, 7, number of conditioned input bits (max 8).
- `CNT_W`, 8, width of each debounce counter and of the filter-length field.

Ports:

- `clk` input 1 — single clock for all logic.
- `rst` input 1 — synchronous, active-high reset.
- `pin_in` input `WIDTH` — already-synchronized `ui_in[WIDTH-1:0]`.
- `address` input 6 — register address.
- `data_in` input 32 — write data.
- `data_write_n` input 2 — `2'b10` = 32-bit write; every other value is ignored.
- `data_out` output 32 — read data, combinational from `address`.
- `cond_out` output `WIDTH` — conditioned bits, fed to PRISM `in_data[WIDTH-1:0]`.
- `edge_irq` output 1 — OR of the enabled edge flags.

## Operation

Registers are written only when `data_write_n == 2'b10`. Unmapped addresses read 0 and ignore writes.

- **0x30 CFG** (R/W):
  - [7:0] `flt_len` N
  - [14:8] `inv_mask`
  - [22:16] `flt_en`
  - other bits read 0.
- **0x34 FLAGS** (R/W1C):
  - [6:0] `rise_flag`
  - [14:8] `fall_flag`
- **0x38 IRQEN** (R/W):
  - [6:0] `rise_en`
  - [14:8] `fall_en`

Per-bit state consists of `stable[i]`, `cnt[i]` (`CNT_W` bits) and `prev[i]`.

**Debounce**, evaluated on each clock per bit:

- Define `mismatch = pin_in[i] != stable[i]`.
- If `mismatch` and the filter is effectively off: `stable <= pin_in`, `cnt <= 0`. "Effectively off" means `flt_en[i]==0`, or `N==0`, or `cnt >= N-1`.
- Else, if `mismatch`: `cnt <= cnt+1`.
- Else (no mismatch): `cnt <= 0`.
- Net effect: `stable` follows `pin_in` only after N consecutive mismatching samples. A glitch shorter than N cycles resets `cnt` and leaves no trace.
- The `>=` compare means that lowering N mid-count never overflows `cnt`. The next mismatching cycle updates `stable` immediately.

**Output:** `cond_out = stable ^ inv_mask` (combinational from registers).

**Edge detection:**

- Every cycle, `prev <= cond_out`.
- Rising edge on bit i: `cond_out[i] & ~prev[i]`. Falling edge: `~cond_out[i] & prev[i]`.
- Changing `inv_mask` flips `cond_out` and therefore does generate edges.
- A detected edge sets the corresponding flag.
- Writing 1 to a flag bit clears it; writing 0 has no effect.
- If a set and a clear hit the same bit in the same cycle, the set wins (flag stays 1).

**Interrupt:** `edge_irq = |((rise_flag & rise_en) | (fall_flag & fall_en))`, combinational from registers.

## Timing

- **Reset:** one `rst` edge clears everything. Every register (CFG, FLAGS, IRQEN, `stable`, `cnt`, `prev`) becomes 0. `cond_out` = 0, `edge_irq` = 0, `data_out` = 0 for every address.
- **Reset mid-count:** any debounce in progress is abandoned. `rst` has priority over register writes issued in the same cycle.
- **Filter off (or N=0/1):**
  - `pin_in` changes before edge k.
  - `cond_out` changes after edge k.
  - The flag is set after edge k+1.
  - `edge_irq` asserts after edge k+1.
- **Filter on with N:** the first mismatching sample is at edge k. `cond_out` changes after edge k+N-1, and the flag sets one edge later.
- **Register writes:** take effect after the writing edge. A new `inv_mask` is visible on `cond_out` in the next cycle.
- **Read timing:** `data_out` is valid in the same cycle as `address`; reads have no side effects.

## Test plan

- **Reset:** drive `pin_in=7'h7F` with `rst=1` for 2 cycles → `cond_out==0`, `edge_irq==0`, and reads of 0x30/0x34/0x38 all return 0. After release, `cond_out==7'h7F` one cycle later and `rise_flag==7'h7F` the following cycle.
- **Debounce:** write CFG with N=5, `flt_en[0]=1`. Pulse `pin_in[0]` high for 4 cycles → `cond_out[0]` stays 0 and FLAGS reads 0. Then hold it high for 5 cycles → `cond_out[0]` rises after the 5th sampling edge and FLAGS reads `0x1`.
- **Invert and interrupt:** write IRQEN = `0x0100` (falling enable on bit 0), then CFG `inv_mask=0x01` with `pin_in=0` → `cond_out[0]` goes 0→1 and `rise_flag[0]` sets, with `edge_irq` staying 0. Driving `pin_in[0]=1` → `fall_flag[0]` sets and `edge_irq=1`.
- **Clear race:** in the same cycle that a new rising edge on bit 2 is detected, write FLAGS = `0x04` → bit 2 reads 1 afterwards. A further write of `0x04` clears it, and `edge_irq` drops.
- **N reduced mid-count:** set N=200 and hold a mismatch for 50 cycles. Write N=10 → `stable` updates at the next mismatching edge, and `cnt` never exceeds 199.
- **Bus qualification:** issue 8/16-bit writes (`data_write_n` = `00`/`01`) to 0x30 → no change. A read of 0x3C returns 0.
